// File: rtl/pipelined_compare_unit.sv
// Pipelined RV32 compare unit: subtract A-B CHUNK bits per stage (LSB first), borrow and zero flag carried forward.
// Latency STAGES cycles, one op/cycle; the whole pipe stalls globally while the output is held unconsumed.
module pipelined_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             cond_o,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int STAGES = WIDTH / CHUNK;

  logic advance;

  // Per-stage inputs: element 0 comes from the ports, element s>0 from stage s-1 registers.
  logic             st_vld  [STAGES];
  logic [WIDTH-1:0] st_a    [STAGES];
  logic [WIDTH-1:0] st_b    [STAGES];
  logic             st_cy   [STAGES];
  logic             st_zr   [STAGES];
  logic             st_amsb [STAGES];
  logic             st_bmsb [STAGES];
  logic [2:0]       st_op   [STAGES];
  logic [TAG_W-1:0] st_tag  [STAGES];

  assign advance    = ~out_valid_o | out_ready_i;
  assign in_ready_o = advance;

  assign st_vld[0]  = in_valid_i;
  assign st_a[0]    = a_i;
  assign st_b[0]    = b_i;
  assign st_cy[0]   = 1'b1;
  assign st_zr[0]   = 1'b1;
  assign st_amsb[0] = a_i[WIDTH-1];
  assign st_bmsb[0] = b_i[WIDTH-1];
  assign st_op[0]   = op_i;
  assign st_tag[0]  = tag_i;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [CHUNK:0] sum;
    logic           zero;

    assign sum  = {1'b0, st_a[s][CHUNK-1:0]} + {1'b0, ~st_b[s][CHUNK-1:0]}
                + {{CHUNK{1'b0}}, st_cy[s]};
    assign zero = st_zr[s] & (sum[CHUNK-1:0] == '0);

    if (s < STAGES - 1) begin : g_mid
      logic             vld_q, cy_q, zr_q, amsb_q, bmsb_q;
      logic [WIDTH-1:0] a_q, b_q;
      logic [2:0]       op_q;
      logic [TAG_W-1:0] tag_q;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld_q  <= 1'b0;
          cy_q   <= 1'b0;
          zr_q   <= 1'b0;
          amsb_q <= 1'b0;
          bmsb_q <= 1'b0;
          a_q    <= '0;
          b_q    <= '0;
          op_q   <= '0;
          tag_q  <= '0;
        end else begin
          if (flush_i)      vld_q <= 1'b0;
          else if (advance) vld_q <= st_vld[s];
          if (advance) begin
            cy_q   <= sum[CHUNK];
            zr_q   <= zero;
            amsb_q <= st_amsb[s];
            bmsb_q <= st_bmsb[s];
            // Shift so the next unprocessed slice always sits at bit 0.
            a_q    <= st_a[s] >> CHUNK;
            b_q    <= st_b[s] >> CHUNK;
            op_q   <= st_op[s];
            tag_q  <= st_tag[s];
          end
        end
      end

      assign st_vld[s+1]  = vld_q;
      assign st_a[s+1]    = a_q;
      assign st_b[s+1]    = b_q;
      assign st_cy[s+1]   = cy_q;
      assign st_zr[s+1]   = zr_q;
      assign st_amsb[s+1] = amsb_q;
      assign st_bmsb[s+1] = bmsb_q;
      assign st_op[s+1]   = op_q;
      assign st_tag[s+1]  = tag_q;
    end else begin : g_last
      logic             borrow, lt, cond_d;
      logic             out_vld_q, cond_q;
      logic [TAG_W-1:0] tag_q;

      always_comb begin
        borrow = ~sum[CHUNK];
        lt     = (st_amsb[s] != st_bmsb[s]) ? st_amsb[s] : borrow;
        cond_d = 1'b0;
        case (st_op[s])
          3'b000:  cond_d = zero;
          3'b001:  cond_d = ~zero;
          3'b100:  cond_d = lt;
          3'b101:  cond_d = ~lt;
          3'b110:  cond_d = borrow;
          3'b111:  cond_d = ~borrow;
          default: cond_d = 1'b0;
        endcase
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          out_vld_q <= 1'b0;
          cond_q    <= 1'b0;
          tag_q     <= '0;
        end else begin
          if (flush_i)      out_vld_q <= 1'b0;
          else if (advance) out_vld_q <= st_vld[s];
          if (advance) begin
            cond_q <= cond_d;
            tag_q  <= st_tag[s];
          end
        end
      end

      assign out_valid_o = out_vld_q;
      assign cond_o      = cond_q;
      assign result_o    = {{(WIDTH-1){1'b0}}, cond_q};
      assign tag_o       = tag_q;
    end
  end

endmodule

// File: tb/tb_pipelined_compare_unit.sv
// Bench for pipelined_compare_unit: default (32/8), wide (64/16) and single-stage (32/32) instances.
module tb_pipelined_compare_unit;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int ST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush, in_valid, out_ready;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic [TW-1:0] tag;
  logic          in_ready, out_valid, cond;
  logic [W-1:0]  result;
  logic [TW-1:0] tag_o;

  pipelined_compare_unit #(.WIDTH(32), .CHUNK(8), .TAG_W(TW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .cond_o(cond), .result_o(result), .tag_o(tag_o));

  logic          w_in_valid, w_in_ready, w_out_valid, w_cond;
  logic [2:0]    w_op;
  logic [63:0]   w_a, w_b, w_result;
  logic [TW-1:0] w_tag_o;

  pipelined_compare_unit #(.WIDTH(64), .CHUNK(16), .TAG_W(TW)) u_wide (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .op_i(w_op), .a_i(w_a), .b_i(w_b), .tag_i(5'd0), .out_valid_o(w_out_valid), .out_ready_i(1'b1),
    .cond_o(w_cond), .result_o(w_result), .tag_o(w_tag_o));

  logic          s_in_valid, s_in_ready, s_out_valid, s_cond;
  logic [2:0]    s_op;
  logic [31:0]   s_a, s_b, s_result;
  logic [TW-1:0] s_tag_o;

  pipelined_compare_unit #(.WIDTH(32), .CHUNK(32), .TAG_W(TW)) u_single (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .op_i(s_op), .a_i(s_a), .b_i(s_b), .tag_i(5'd0), .out_valid_o(s_out_valid), .out_ready_i(1'b1),
    .cond_o(s_cond), .result_o(s_result), .tag_o(s_tag_o));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference compare straight from the ISA definition of each mode.
  function automatic bit ref_cond(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                                  input int w);
    logic [63:0] ux, uy;
    longint      sx, sy;
    bit          eq, lt, ltu;
    if (w == 32) begin
      ux = {32'b0, x[31:0]};
      uy = {32'b0, y[31:0]};
      sx = longint'($signed(x[31:0]));
      sy = longint'($signed(y[31:0]));
    end else begin
      ux = x;
      uy = y;
      sx = $signed(x);
      sy = $signed(y);
    end
    eq  = (ux == uy);
    ltu = (ux < uy);
    lt  = (sx < sy);
    case (o)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard: each accepted op with its count of pipeline advances since acceptance.
  typedef struct {
    bit            cnd;
    logic [TW-1:0] tg;
    int            age;
  } item_t;
  item_t q[$];

  always @(negedge clk) begin
    bit    ev, adv;
    item_t it;
    ev = (q.size() > 0) && (q[0].age >= ST);
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(!ev || out_ready));
      if (ev) begin
        chk("cond", 64'(cond), 64'(q[0].cnd));
        chk("result", 64'(result), 64'(q[0].cnd));
        chk("tag", 64'(tag_o), 64'(q[0].tg));
      end
    end
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      adv = !ev || out_ready;
      if (ev && out_ready) void'(q.pop_front());
      if (adv) begin
        foreach (q[i]) q[i].age++;
        if (in_valid) begin
          it.cnd = ref_cond(op, 64'(a), 64'(b), 32);
          it.tg  = tag;
          it.age = 1;
          q.push_back(it);
        end
      end
    end
  end

  task automatic reset_checks(input string nm);
    chk({nm, "_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_cond"}, 64'(cond), 64'd0);
    chk({nm, "_result"}, 64'(result), 64'd0);
    chk({nm, "_tag"}, 64'(tag_o), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic issue_check(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [TW-1:0] t, input bit e, input string nm);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y; tag = t; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(ST));
    chk({nm, "_cond"}, 64'(cond), 64'(e));
    chk({nm, "_result"}, 64'(result), 64'(e));
    chk({nm, "_tag"}, 64'(tag_o), 64'(t));
  endtask

  task automatic run_wide(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                          input bit e, input string nm);
    int lat;
    @(posedge clk); #1;
    w_in_valid = 1'b1; w_op = o; w_a = x; w_b = y;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    chk({nm, "_cond"}, 64'(w_cond), 64'(e));
    chk({nm, "_result"}, w_result, 64'(e));
  endtask

  task automatic run_single(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            input bit e, input string nm);
    int lat;
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_op = o; s_a = x; s_b = y;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd1);
    chk({nm, "_cond"}, 64'(s_cond), 64'(e));
    chk({nm, "_result"}, 64'(s_result), 64'(e));
  endtask

  initial begin
    int          sent;
    logic [31:0] ra, rb;
    logic [63:0] wa, wb;
    logic [2:0]  ro;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; tag = '0;
    w_in_valid = 1'b0; w_op = '0; w_a = '0; w_b = '0;
    s_in_valid = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;

    issue_check(3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 5'd1, 1'b1, "ltu_basic");
    issue_check(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 5'd2, 1'b0, "ltu_swap");
    issue_check(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b1, "lt_neg");
    issue_check(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4, 1'b0, "ltu_neg");
    issue_check(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 1'b0, "ge_neg");
    issue_check(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 1'b1, "geu_neg");
    issue_check(3'b000, 32'h8000_00FF, 32'h8000_00FF, 5'd7, 1'b1, "eq_same");
    issue_check(3'b001, 32'h8000_00FF, 32'h8000_00FF, 5'd8, 1'b0, "ne_same");
    issue_check(3'b000, 32'h8000_00FF, 32'h0000_00FF, 5'd9, 1'b0, "eq_upper");
    issue_check(3'b010, 32'h0000_0005, 32'h0000_0005, 5'd10, 1'b0, "illegal_010");
    issue_check(3'b011, 32'h0000_0001, 32'h0000_0002, 5'd11, 1'b0, "illegal_011");

    // Backpressure: 8 ops, consumer stalled in cycles 5..9.
    @(posedge clk); #1;
    sent = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 9);
      in_valid  = (sent < 8);
      tag       = TW'(sent);
      op        = 3'($urandom);
      a         = $urandom;
      b         = $urandom;
      @(negedge clk);
      if (cyc >= 5 && cyc <= 9) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 64'(sent), 64'd8);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Flush in the cycle the third op is accepted.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 3'b001; a = $urandom; b = ~a; tag = TW'(12 + i);
      flush = (i == 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush_quiet", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    issue_check(3'b100, 32'h0000_0003, 32'h8000_0000, 5'd20, 1'b0, "post_flush");

    // Reset with two ops in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; op = 3'b001; a = 32'h1234_5678; b = 32'h0; tag = TW'(25 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    reset_checks("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_reset_quiet", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end

    // Randomized traffic with backpressure, flushes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      flush     = ($urandom % 50) == 0;
      rst_n     = ($urandom % 300) != 0;
      op        = 3'($urandom);
      a         = $urandom;
      case ($urandom % 4)
        0:       b = a;
        1:       b = a ^ (32'h1 << ($urandom % 32));
        2:       b = ~a;
        default: b = $urandom;
      endcase
      tag = TW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("random_drained", 64'(q.size()), 64'd0);

    // Wide instance: 64-bit operands, 16-bit slices.
    run_wide(3'b110, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "w64_ltu");
    run_wide(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "w64_ltu_swap");
    run_wide(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, "w64_lt");
    run_wide(3'b000, 64'h8000_0000_0000_00FF, 64'h0000_0000_0000_00FF, 1'b0, "w64_eq_upper");
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom);
      wa = {$urandom, $urandom};
      wb = (i % 3 == 0) ? wa : ((i % 3 == 1) ? {wa[63:32], $urandom} : {$urandom, $urandom});
      run_wide(ro, wa, wb, ref_cond(ro, wa, wb, 64), "w64_rand");
    end

    // Single-stage instance: registered comparator, latency 1.
    run_single(3'b110, 32'h1, 32'hFFFF_FFFF, 1'b1, "s1_ltu");
    run_single(3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1, "s1_lt");
    run_single(3'b111, 32'hFFFF_FFFF, 32'h1, 1'b1, "s1_geu");
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = (i % 2 == 0) ? ra : $urandom;
      run_single(ro, ra, rb, ref_cond(ro, 64'(ra), 64'(rb), 32), "s1_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_compare_unit.md
Name: pipelined_compare_unit

Overview:
Parametrised, pipelined integer comparator. It generalises the single-cycle unsigned set-less-than to every RV32 compare mode: EQ, NE, LT, GE, LTU and GEU. It serves both the ALU SLT/SLTU path and the branch-resolution unit. The subtract is split into CHUNK-bit slices, one slice per pipeline stage, with the borrow carried between stages. A valid/ready handshake with backpressure and a synchronous flush connect it to the execute stage.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits of subtraction resolved per stage; STAGES = WIDTH/CHUNK.
TAG_W, 5, width of the sideband tag (e.g. rd index) carried with each operation.

Ports:
clk_i  in  1  clock, all state updates on the rising edge.
rst_ni  in  1  synchronous reset, active low.
flush_i  in  1  synchronous flush; kills all in-flight operations.
in_valid_i  in  1  operation offered.
in_ready_o  out  1  unit can accept an operation this cycle.
op_i  in  3  compare mode, using branch funct3 encoding: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
a_i  in  WIDTH  operand A (rs1).
b_i  in  WIDTH  operand B (rs2).
tag_i  in  TAG_W  sideband, returned unchanged.
out_valid_o  out  1  result valid.
out_ready_i  in  1  consumer accepts the result.
cond_o  out  1  compare outcome for op.
result_o  out  WIDTH  {(WIDTH-1) zeros, cond_o}; SLT/SLTU writeback value.
tag_o  out  TAG_W  tag of the operation on the output.

Behaviour:
- Reset: when rst_ni=0 at a rising edge, all stage valid bits clear and all datapath registers go to 0. out_valid_o=0, cond_o=0, result_o=0, tag_o=0. in_ready_o=1 during the first cycle after reset.
- Opcodes 010 and 011 are illegal. They are accepted normally and produce cond_o=0.
- Arithmetic: D = A + ~B + 1, computed CHUNK bits per stage.
  - Stage k adds slice k (LSB first) using the carry registered by stage k-1. Stage 0 has carry-in 1.
  - Each stage registers an accumulated zero flag (all slices so far have difference 0). It also forwards the unprocessed upper operand slices, op, tag and the operand sign bits a[WIDTH-1] and b[WIDTH-1].
  - Final borrow = NOT carry-out of the top slice.
- Outcomes:
  - eq = accumulated zero.
  - ltu = borrow.
  - lt = (a_msb != b_msb) ? a_msb : borrow.
  - EQ → eq, NE → ~eq, LT → lt, GE → ~lt, LTU → ltu, GEU → ~ltu.
- Latency: exactly STAGES cycles from an accepted input (in_valid_i & in_ready_o) to out_valid_o, when there is no stall. Throughput is one operation per cycle.
- Outputs cond_o, result_o and tag_o are registered in the last stage. They hold stable while out_valid_o=1 and out_ready_i=0.
- Handshake:
  - advance = ~out_valid_o | out_ready_i. The whole pipeline moves only when advance=1 (global stall).
  - in_ready_o = advance, purely combinational from out_valid_o and out_ready_i; it never depends on in_valid_i.
  - Bubbles propagate as stage valid=0 and do not block acceptance.
  - out_valid_o, once asserted, never drops before out_ready_i, except on flush or reset.
- Flush:
  - flush_i=1 clears every stage valid bit at the next edge and discards any input offered that cycle. out_valid_o=0 in the following cycle.
  - Datapath registers need not clear on flush.
- Simultaneous events: reset dominates flush; flush dominates accept and advance. A result presented with out_ready_i=1 in the same cycle as flush_i=1 counts as consumed.
- Reset mid-operation: all in-flight results are lost, and no out_valid_o pulse appears after reset release until new inputs have been accepted.
- STAGES=1 (CHUNK=WIDTH) degenerates to a single registered comparator with 1-cycle latency.

Test Plan:
- Basic LTU, default params: A=0x0000_0001, B=0xFFFF_FFFF, op=110 → after 4 cycles out_valid_o=1, cond_o=1, result_o=0x0000_0001. Swapping operands gives cond_o=0.
- Signed vs unsigned: A=0xFFFF_FFFF (−1), B=0x0000_0001. op=100 (LT) → cond_o=1; op=110 (LTU) → cond_o=0; op=101 (GE) → 0; op=111 (GEU) → 1.
- Equality across slices: A=B=0x8000_00FF with op=000 → 1 and op=001 → 0. A=0x8000_00FF, B=0x0000_00FF with op=000 → 0, which checks that the upper-slice difference is seen.
- Backpressure: stream 8 back-to-back operations, holding out_ready_i=0 for cycles 5–9. Required: in_ready_o=0 during the stall, output held stable, all 8 results delivered in order with correct tags 0..7, none lost or duplicated.
- Flush: issue 3 operations, assert flush_i in the cycle the 3rd is accepted. Required: no out_valid_o in the following 4 cycles, and the next accepted operation is delivered with 4-cycle latency.
- Reset mid-stream and parameters: assert rst_ni=0 with 2 operations in flight → all outputs 0 the next cycle and no stale results afterward. Repeat the LTU and LT checks with WIDTH=64, CHUNK=16, and with CHUNK=WIDTH (latency 1).
